// File: rtl/button_bank_debouncer_pkg.sv
// Shared defaults and board constants for the button bank debouncer.
// Optional auto-repeat is enabled by defining BTN_BANK_AUTO_REPEAT_EN.
package btn_bank_pkg;

    localparam int DEF_N_CH          = 5;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_CNT_W         = 20;
    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY  = 500000;
    localparam int DEF_REPEAT_PERIOD = 100000;

    // Channels 0..3 are wired active-low on the board, channel 4 active-high.
    localparam logic [4:0] BOARD_BTN_INVERT_MASK = 5'b01111;

    function automatic bit fits_counter(input longint value, input int width);
        return (value >= 0) && (value < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/button_bank_debouncer_if.sv
// Pin-side and event-side signals of the button bank debouncer.
// master = debouncer (drives levels and strobes), slave = board/consumer side.
interface button_bank_debouncer_if
    import btn_bank_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);

    logic [N_CH-1:0] Input;
    logic [N_CH-1:0] Output;
    logic [N_CH-1:0] PressPulse;
    logic [N_CH-1:0] ReleasePulse;
    logic [N_CH-1:0] RepeatPulse;
    logic            AnyPress;

    modport master (
        input  Input,
        output Output, PressPulse, ReleasePulse, RepeatPulse, AnyPress
    );

    modport slave (
        output Input,
        input  Output, PressPulse, ReleasePulse, RepeatPulse, AnyPress
    );

endinterface

// File: rtl/button_bank_debouncer_ch.sv
// One debounce channel: synchroniser, polarity fix, stability counter, strobes.
// Auto-repeat counter is built only when BTN_BANK_AUTO_REPEAT_EN is defined.
module button_debounce_ch
    import btn_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit INVERT        = 1'b0,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic press_next
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1 || !fits_counter(longint'(STABLE_CYCLES), CNT_W)) begin : g_bad_stable
        $error("STABLE_CYCLES must be in 1..2^CNT_W-1");
    end
    if (REPEAT_DELAY < 1 || !fits_counter(longint'(REPEAT_DELAY), CNT_W)) begin : g_bad_delay
        $error("REPEAT_DELAY must be in 1..2^CNT_W-1");
    end
    if (REPEAT_PERIOD < 1 || !fits_counter(longint'(REPEAT_PERIOD), CNT_W)) begin : g_bad_period
        $error("REPEAT_PERIOD must be in 1..2^CNT_W-1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q;
    logic                   s;
    logic                   flip;

    // Reset loads the inactive pin level so an active-low pin reads as released.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{INVERT}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        cnt_d = '0;
        flip  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) flip  = 1'b1;
            else                                    cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign press_next = flip & s;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            level_q       <= 1'b0;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level_q       <= flip ? s : level_q;
            cnt_q         <= cnt_d;
            press_pulse   <= flip & s;
            release_pulse <= flip & ~s;
        end
    end

    assign level = level_q;

`ifdef BTN_BANK_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rc_q;
    logic             armed_q;
    logic             rep_q;
    logic             level_d;
    logic [CNT_W-1:0] rc_target;

    assign level_d   = flip ? s : level_q;
    assign rc_target = armed_q ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);

    // A new press restarts the delay; a release clears it in the same edge.
    always_ff @(posedge clk) begin
        if (rst || !level_d || press_next) begin
            rc_q    <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
        end else if (rc_q == rc_target) begin
            rc_q    <= '0;
            armed_q <= 1'b1;
            rep_q   <= 1'b1;
        end else begin
            rc_q    <= rc_q + CNT_W'(1);
            rep_q   <= 1'b0;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_bank_debouncer.sv
// N-channel button debouncer with press/release strobes and registered AnyPress.
// Define BTN_BANK_AUTO_REPEAT_EN to build the per-channel auto-repeat strobes.
module button_bank_debouncer
    import btn_bank_pkg::*;
#(
    parameter int              N_CH          = DEF_N_CH,
    parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int              CNT_W         = DEF_CNT_W,
    parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic [N_CH-1:0] INVERT_MASK   = N_CH'(BOARD_BTN_INVERT_MASK),
    parameter int              REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int              REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                    Clk,
    input  logic                    Reset,
    button_bank_debouncer_if.master bus
);

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] press_w;
    logic [N_CH-1:0] release_w;
    logic [N_CH-1:0] repeat_w;
    logic [N_CH-1:0] press_next_w;
    logic            any_press_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .INVERT       (INVERT_MASK[i]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk          (Clk),
            .rst          (Reset),
            .pin          (bus.Input[i]),
            .level        (level_w[i]),
            .press_pulse  (press_w[i]),
            .release_pulse(release_w[i]),
            .repeat_pulse (repeat_w[i]),
            .press_next   (press_next_w[i])
        );
    end

    // Registered from the same next-state terms as PressPulse, so both rise together.
    always_ff @(posedge Clk) begin
        if (Reset) any_press_q <= 1'b0;
        else       any_press_q <= |press_next_w;
    end

    assign bus.Output       = level_w;
    assign bus.PressPulse   = press_w;
    assign bus.ReleasePulse = release_w;
    assign bus.RepeatPulse  = repeat_w;
    assign bus.AnyPress     = any_press_q;

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Scoreboard bench for button_bank_debouncer: N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2, INVERT_MASK=4'b0001.
// Repeat expectations are added when BTN_BANK_AUTO_REPEAT_EN is defined.
module tb_button_bank_debouncer;

    localparam int N = 4;

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] lvl;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    ev_t  exp_q[$];

    button_bank_debouncer_if #(.N_CH(N)) bus ();

    button_bank_debouncer #(
        .N_CH         (N),
        .SYNC_STAGES  (2),
        .CNT_W        (8),
        .STABLE_CYCLES(4),
        .INVERT_MASK  (4'b0001),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                                      input logic [3:0] rp, input logic [3:0] l);
        ev_t e;
        e.at = at; e.press = p; e.rel = r; e.rep = rp; e.lvl = l;
        exp_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any strobe activity must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if ((bus.PressPulse | bus.ReleasePulse | bus.RepeatPulse) != '0 || bus.AnyPress) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe",
                      32'({bus.PressPulse, bus.ReleasePulse, bus.RepeatPulse, bus.AnyPress}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle",  32'(cyc),              32'(e.at));
                check("press_pulse",  32'(bus.PressPulse),   32'(e.press));
                check("release_pulse",32'(bus.ReleasePulse), 32'(e.rel));
                check("repeat_pulse", 32'(bus.RepeatPulse),  32'(e.rep));
                check("any_press",    32'(bus.AnyPress),     32'(|e.press));
                check("level",        32'(bus.Output),       32'(e.lvl));
            end
        end
    end

    // Channel-2 bounce pattern, one value per cycle, ending on the final 0->1.
    localparam int BOUNCE_LEN = 5;
    logic bounce [BOUNCE_LEN] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int c;
        int p;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.Input = 4'b0001;

        // Reset with the active-low channel idle-high: no press may appear.
        wait_cyc(3);
        check("reset_output", 32'(bus.Output), 32'd0);
        check("reset_strobes", 32'({bus.PressPulse, bus.ReleasePulse, bus.RepeatPulse, bus.AnyPress}), 32'd0);
        rst = 1'b0;
        wait_cyc(20);
        check("post_reset_output", 32'(bus.Output), 32'd0);

        // Ch1 clean step up, then back down.
        c = cyc;
        bus.Input = 4'b0011;
        expect_ev(c + 6, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        wait_cyc(5);
        check("ch1_level_before", 32'(bus.Output), 32'd0);
        wait_cyc(2);
        check("ch1_level_after", 32'(bus.Output), 32'b0010);
        wait_cyc(1);
        bus.Input = 4'b0001;
        expect_ev(c + 14, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_cyc(12);

        // Ch2 bounce; the 0 arrives exactly when the count would have completed.
        c = cyc;
        for (int i = 0; i < BOUNCE_LEN; i++) begin
            bus.Input = {1'b0, bounce[i], 2'b01};
            if (i < BOUNCE_LEN - 1) wait_cyc(1);
        end
        p = c + 10;
        expect_ev(p, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
`ifdef BTN_BANK_AUTO_REPEAT_EN
        expect_ev(p + 10, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        expect_ev(p + 13, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        expect_ev(p + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
        expect_ev(p + 18, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_cyc(p + 12 - cyc);
        bus.Input = 4'b0001;
        wait_cyc(25);
        check("ch2_released", 32'(bus.Output), 32'd0);

        // Ch0 is active-low: driving the pin low is a press.
        c = cyc;
        bus.Input = 4'b0000;
        expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(8);
        check("ch0_level", 32'(bus.Output), 32'b0001);
        bus.Input = 4'b0001;
        expect_ev(c + 14, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(12);

        // Ch1 and ch3 together.
        c = cyc;
        bus.Input = 4'b1011;
        expect_ev(c + 6, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
        wait_cyc(8);
        bus.Input = 4'b0001;
        expect_ev(c + 14, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
        wait_cyc(12);

        // Ch2 held, ch3 mid-count, then reset: both discarded silently.
        c = cyc;
        bus.Input = 4'b0101;
        expect_ev(c + 6, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
`ifdef BTN_BANK_AUTO_REPEAT_EN
        expect_ev(c + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
        wait_cyc(14);
        bus.Input = 4'b1101;
        wait_cyc(3);
        rst = 1'b1;
        bus.Input = 4'b0001;
        wait_cyc(1);
        check("reset_mid_output", 32'(bus.Output), 32'd0);
        check("reset_mid_repeat", 32'(bus.RepeatPulse), 32'd0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);
        check("after_mid_reset_output", 32'(bus.Output), 32'd0);

        // Bounded drain: every expected event must have been consumed.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cyc(1);
        check("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
